// File: rtl/branch_pred_ctrl_if.sv
// Signal bundle between branch_pred_ctrl (slave) and its fetch/execute/predictor
// environment (master).
interface branch_pred_ctrl_if;
    logic       lookup_valid;
    logic       lookup_ready;
    logic       pred_valid;
    logic       pred_taken;
    logic       resolve_valid;
    logic       resolve_taken;
    logic       mispredict;
    logic       resolve_err;
    logic       pred_request;
    logic       pred_prediction;
    logic       pred_result;
    logic       pred_actual;
    logic [2:0] inflight_count;
    logic [7:0] mispredict_cnt;

    modport slave (
        input  lookup_valid, resolve_valid, resolve_taken, pred_prediction,
        output lookup_ready, pred_valid, pred_taken, mispredict, resolve_err,
               pred_request, pred_result, pred_actual, inflight_count, mispredict_cnt
    );

    modport master (
        output lookup_valid, resolve_valid, resolve_taken, pred_prediction,
        input  lookup_ready, pred_valid, pred_taken, mispredict, resolve_err,
               pred_request, pred_result, pred_actual, inflight_count, mispredict_cnt
    );
endinterface

// File: rtl/branch_pred_ctrl.sv
// Branch prediction controller: tracks outstanding predictions in a FIFO, checks them
// against resolved outcomes and flushes on a mispredict.
module branch_pred_ctrl #(
    parameter int DEPTH = 4
) (
    input logic               clk,
    input logic               rst_n,
    branch_pred_ctrl_if.slave bp
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

    logic [0:0]       r_state;
    logic [DEPTH-1:0] r_fifo;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_pred_valid;
    logic             r_mispredict;
    logic             r_resolve_err;
    logic [7:0]       r_mispredict_cnt;

    logic [CNT_W-1:0] w_inflight;
    logic             w_ready;
    logic             w_accept;
    logic             w_pop;
    logic             w_mispred;
    logic             w_push;
    logic             w_err;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        if (ptr == PTR_W'(DEPTH - 1)) begin
            next_ptr = {PTR_W{1'b0}};
        end else begin
            next_ptr = ptr + PTR_W'(1);
        end
    endfunction

    // The pending prediction occupies a slot but cannot be popped until it lands in the FIFO.
    assign w_inflight = r_count + CNT_W'(r_pred_valid);
    assign w_ready    = rst_n && (r_state == ST_RUN) && (w_inflight < DEPTH_C);
    assign w_accept   = bp.lookup_valid && w_ready;
    assign w_pop      = rst_n && bp.resolve_valid && (r_count != {CNT_W{1'b0}});
    assign w_mispred  = w_pop && (r_fifo[r_rd_ptr] != bp.resolve_taken);
    assign w_push     = r_pred_valid && !w_mispred;
    assign w_err      = bp.resolve_valid && (r_count == {CNT_W{1'b0}});

    assign bp.lookup_ready   = w_ready;
    assign bp.pred_request   = w_accept;
    assign bp.pred_valid     = r_pred_valid;
    assign bp.pred_taken     = r_pred_valid ? bp.pred_prediction : 1'b0;
    assign bp.pred_result    = w_pop;
    assign bp.pred_actual    = w_pop ? bp.resolve_taken : 1'b0;
    assign bp.mispredict     = r_mispredict;
    assign bp.resolve_err    = r_resolve_err;
    assign bp.inflight_count = 3'(w_inflight);
    assign bp.mispredict_cnt = r_mispredict_cnt;

    // FSM, FIFO bookkeeping, strobes and mispredict counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= ST_RUN;
            r_fifo           <= {DEPTH{1'b0}};
            r_wr_ptr         <= {PTR_W{1'b0}};
            r_rd_ptr         <= {PTR_W{1'b0}};
            r_count          <= {CNT_W{1'b0}};
            r_pred_valid     <= 1'b0;
            r_mispredict     <= 1'b0;
            r_resolve_err    <= 1'b0;
            r_mispredict_cnt <= 8'd0;
        end else begin
            case (r_state)
                ST_RUN:   r_state <= w_mispred ? ST_FLUSH : ST_RUN;
                ST_FLUSH: r_state <= ST_RUN;
                default:  r_state <= ST_RUN;
            endcase
            r_mispredict  <= w_mispred;
            r_resolve_err <= w_err;
            r_pred_valid  <= w_accept && !w_mispred;
            if (w_mispred) begin
                r_count  <= {CNT_W{1'b0}};
                r_wr_ptr <= {PTR_W{1'b0}};
                r_rd_ptr <= {PTR_W{1'b0}};
                if (r_mispredict_cnt != 8'hFF) begin
                    r_mispredict_cnt <= r_mispredict_cnt + 8'd1;
                end
            end else begin
                if (w_push) begin
                    r_fifo[r_wr_ptr] <= bp.pred_taken;
                    r_wr_ptr         <= next_ptr(r_wr_ptr);
                end
                if (w_pop) begin
                    r_rd_ptr <= next_ptr(r_rd_ptr);
                end
                r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
            end
        end
    end
endmodule

// File: tb/tb_branch_pred_ctrl.sv
// Directed self-checking bench for branch_pred_ctrl with a 2-bit saturating-counter
// predictor model attached to the predictor side.
module tb_branch_pred_ctrl;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_mis;
    int   m_ctr;
    logic [1:0] r_pctr;
    logic       r_pred;

    branch_pred_ctrl_if bp();

    branch_pred_ctrl #(.DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bp    (bp)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Predictor: registers its prediction on a request, trains on a result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pctr <= 2'd0;
            r_pred <= 1'b0;
        end else begin
            if (bp.pred_request) r_pred <= r_pctr[1];
            if (bp.pred_result) begin
                if (bp.pred_actual && r_pctr != 2'd3) r_pctr <= r_pctr + 2'd1;
                else if (!bp.pred_actual && r_pctr != 2'd0) r_pctr <= r_pctr - 2'd1;
            end
        end
    end
    assign bp.pred_prediction = r_pred;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Asserts reset between edges and checks that everything clears without a clock.
    task automatic apply_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        bp.lookup_valid  = 1'b1;
        bp.resolve_valid = 1'b1;
        #1;
        check_val("rst_ready",    bp.lookup_ready,   32'd0);
        check_val("rst_request",  bp.pred_request,   32'd0);
        check_val("rst_result",   bp.pred_result,    32'd0);
        check_val("rst_inflight", bp.inflight_count, 32'd0);
        check_val("rst_mcnt",     bp.mispredict_cnt, 32'd0);
        check_val("rst_pvalid",   bp.pred_valid,     32'd0);
        check_val("rst_mispred",  bp.mispredict,     32'd0);
        check_val("rst_err",      bp.resolve_err,    32'd0);
        @(posedge clk);
        #1;
        bp.lookup_valid  = 1'b0;
        bp.resolve_valid = 1'b0;
        rst_n = 1'b1;
        m_ctr = 0;
    endtask

    // One lookup followed by its resolve; checks prediction and mispredict outcome.
    task automatic run_branch(input logic act, input logic exp_pred, input logic exp_mis);
        next_cycle();
        bp.lookup_valid = 1'b1;
        #1;
        check_val("br_request", bp.pred_request, 32'd1);
        next_cycle();
        bp.lookup_valid = 1'b0;
        #1;
        check_val("br_pvalid", bp.pred_valid, 32'd1);
        check_val("br_ptaken", bp.pred_taken, {31'd0, exp_pred});
        next_cycle();
        bp.resolve_valid = 1'b1;
        bp.resolve_taken = act;
        #1;
        check_val("br_result", bp.pred_result, 32'd1);
        check_val("br_actual", bp.pred_actual, {31'd0, act});
        next_cycle();
        bp.resolve_valid = 1'b0;
        #1;
        check_val("br_mispred", bp.mispredict, {31'd0, exp_mis});
        check_val("br_ready", bp.lookup_ready, {31'd0, !exp_mis});
        next_cycle();
        check_val("br_ready_after", bp.lookup_ready, 32'd1);
        if (act) begin
            if (m_ctr != 3) m_ctr++;
        end else begin
            if (m_ctr != 0) m_ctr--;
        end
    endtask

    initial begin
        n_cmp = 0;
        n_mis = 0;
        m_ctr = 0;
        rst_n = 1'b0;
        bp.lookup_valid  = 1'b0;
        bp.resolve_valid = 1'b0;
        bp.resolve_taken = 1'b0;
        apply_reset();

        // First lookup after reset with a fresh predictor.
        next_cycle();
        bp.lookup_valid = 1'b1;
        #1;
        check_val("c1_request", bp.pred_request, 32'd1);
        next_cycle();
        bp.lookup_valid = 1'b0;
        #1;
        check_val("c2_pvalid",   bp.pred_valid,     32'd1);
        check_val("c2_ptaken",   bp.pred_taken,     32'd0);
        check_val("c2_inflight", bp.inflight_count, 32'd1);
        next_cycle();
        bp.resolve_valid = 1'b1;
        bp.resolve_taken = 1'b0;
        #1;
        check_val("c3_inflight", bp.inflight_count, 32'd1);
        check_val("c3_result",   bp.pred_result,    32'd1);
        next_cycle();
        bp.resolve_valid = 1'b0;
        #1;
        check_val("c4_mispred",  bp.mispredict,     32'd0);
        check_val("c4_inflight", bp.inflight_count, 32'd0);

        // Resolve with nothing outstanding.
        next_cycle();
        bp.resolve_valid = 1'b1;
        bp.resolve_taken = 1'b1;
        #1;
        check_val("err_result", bp.pred_result, 32'd0);
        next_cycle();
        bp.resolve_valid = 1'b0;
        #1;
        check_val("err_flag", bp.resolve_err,    32'd1);
        check_val("err_mcnt", bp.mispredict_cnt, 32'd0);
        check_val("err_mis",  bp.mispredict,     32'd0);
        next_cycle();
        check_val("err_clear", bp.resolve_err, 32'd0);

        // Fill to DEPTH, refuse a fifth lookup, free a slot.
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            bp.lookup_valid = 1'b1;
            #1;
            check_val("fill_ready", bp.lookup_ready, 32'd1);
        end
        next_cycle();
        check_val("full_ready",    bp.lookup_ready,   32'd0);
        check_val("full_request",  bp.pred_request,   32'd0);
        check_val("full_inflight", bp.inflight_count, 32'd4);
        next_cycle();
        check_val("full_hold", bp.inflight_count, 32'd4);
        next_cycle();
        bp.resolve_valid = 1'b1;
        bp.resolve_taken = 1'b0;
        #1;
        check_val("pop_ready",  bp.lookup_ready, 32'd0);
        check_val("pop_result", bp.pred_result,  32'd1);
        next_cycle();
        bp.resolve_valid = 1'b0;
        bp.lookup_valid  = 1'b0;
        #1;
        check_val("freed_ready",    bp.lookup_ready,   32'd1);
        check_val("freed_inflight", bp.inflight_count, 32'd3);
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            bp.resolve_valid = 1'b1;
            bp.resolve_taken = 1'b0;
        end
        next_cycle();
        bp.resolve_valid = 1'b0;
        #1;
        check_val("drain_inflight", bp.inflight_count, 32'd0);
        check_val("drain_mcnt",     bp.mispredict_cnt, 32'd0);

        // Three outstanding, oldest mispredicts while a push and a lookup land together.
        next_cycle();
        bp.lookup_valid = 1'b1;
        next_cycle();
        next_cycle();
        next_cycle();
        bp.resolve_valid = 1'b1;
        bp.resolve_taken = 1'b1;
        #1;
        check_val("fl_inflight_pre", bp.inflight_count, 32'd3);
        check_val("fl_request",      bp.pred_request,   32'd1);
        check_val("fl_result",       bp.pred_result,    32'd1);
        next_cycle();
        bp.resolve_valid = 1'b0;
        #1;
        check_val("fl_mispred",  bp.mispredict,     32'd1);
        check_val("fl_inflight", bp.inflight_count, 32'd0);
        check_val("fl_ready",    bp.lookup_ready,   32'd0);
        check_val("fl_request0", bp.pred_request,   32'd0);
        check_val("fl_pvalid",   bp.pred_valid,     32'd0);
        check_val("fl_mcnt",     bp.mispredict_cnt, 32'd1);
        next_cycle();
        bp.lookup_valid = 1'b0;
        #1;
        check_val("fl_ready_back", bp.lookup_ready,   32'd1);
        check_val("fl_mis_clear",  bp.mispredict,     32'd0);
        check_val("fl_inflight2",  bp.inflight_count, 32'd0);

        // Predictor training through two mispredicts.
        apply_reset();
        run_branch(1'b1, 1'b0, 1'b1);
        run_branch(1'b1, 1'b0, 1'b1);
        check_val("train_mcnt", bp.mispredict_cnt, 32'd2);
        run_branch(1'b1, 1'b1, 1'b0);
        check_val("train_mcnt2", bp.mispredict_cnt, 32'd2);

        // Saturation of the mispredict counter.
        apply_reset();
        for (int i = 0; i < 256; i++) begin
            run_branch(m_ctr < 2, m_ctr >= 2, 1'b1);
            if (i == 253) check_val("sat_254", bp.mispredict_cnt, 32'd254);
        end
        check_val("sat_255", bp.mispredict_cnt, 32'd255);

        // Asynchronous reset with branches in flight.
        next_cycle();
        bp.lookup_valid = 1'b1;
        next_cycle();
        next_cycle();
        bp.lookup_valid = 1'b0;
        #1;
        check_val("mid_inflight", bp.inflight_count, 32'd2);
        apply_reset();
        next_cycle();
        check_val("post_inflight", bp.inflight_count, 32'd0);
        check_val("post_ready",    bp.lookup_ready,   32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule

// File: doc/branch_pred_ctrl.md
BRANCH_PRED_CTRL -- requirements
Module: branch_pred_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk (input, 1, rising-edge clock) and rst_n (input, 1, async active-low reset).
REQ-002 Fetch side SHALL be: lookup_valid (in, 1, branch lookup request), lookup_ready (out, 1, lookup can be accepted), pred_valid (out, 1, prediction strobe), pred_taken (out, 1, predicted direction).
REQ-003 Execute side SHALL be: resolve_valid (in, 1, oldest branch resolved), resolve_taken (in, 1, actual direction), mispredict (out, 1, one-cycle flush pulse), resolve_err (out, 1, resolve with nothing outstanding).
REQ-004 Predictor side SHALL be: pred_request (out, 1, drives predictor request), pred_prediction (in, 1, predictor prediction output), pred_result (out, 1, drives predictor result), pred_actual (out, 1, drives predictor taken).
REQ-005 Status outputs SHALL be: inflight_count (out, 3, FIFO entries plus pending prediction, 0..4) and mispredict_cnt (out, 8, saturating mispredict count).
REQ-006 Parameter: DEPTH, default 4, outstanding-branch FIFO depth; only 4 is required to be supported.

Function
REQ-007 States: RUN and FLUSH. RUN is the normal state. FLUSH lasts exactly one cycle and then returns to RUN.
REQ-008 lookup_ready SHALL be 1 iff state==RUN and inflight_count<DEPTH. A lookup is accepted in cycle N when lookup_valid && lookup_ready.
REQ-009 pred_request SHALL equal the accept condition combinationally in cycle N. The predictor registers its prediction at the end of N.
REQ-010 pred_valid SHALL be registered and high in cycle N+1 for each lookup accepted in N. pred_taken SHALL equal pred_prediction (combinational) while pred_valid=1, else 0.
REQ-011 At the end of any cycle with pred_valid=1 and no squash (REQ-015), pred_taken SHALL be pushed into the FIFO. Back-to-back lookups SHALL be accepted every cycle while lookup_ready=1.
REQ-012 A resolve in cycle M with FIFO non-empty (pending entry excluded) SHALL pop the oldest entry. pred_result=1 and pred_actual=resolve_taken SHALL be driven combinationally in M.
REQ-013 A resolve in cycle M with the FIFO empty SHALL assert registered resolve_err for one cycle (M+1). It SHALL cause no pop, no pred_result and no counter change.
REQ-014 If the popped entry is not equal to resolve_taken, mispredict SHALL pulse in M+1, state SHALL be FLUSH in M+1, and mispredict_cnt SHALL increment, saturating at 255.
REQ-015 On a mispredict in M, at the end of M: all remaining FIFO entries SHALL be discarded, a same-cycle push from pred_valid SHALL be dropped, and any lookup accepted in M SHALL have its pred_valid in M+1 suppressed (its predictor request still occurs).
REQ-016 A push and a pop in the same cycle SHALL both take effect. Occupancy SHALL be unchanged except as REQ-015 requires.
REQ-017 inflight_count SHALL equal FIFO occupancy plus the registered pred_valid. It SHALL never exceed DEPTH. FIFO pointers SHALL wrap modulo DEPTH.
REQ-018 When inflight_count==DEPTH, lookup_ready SHALL be 0. A pop in that cycle SHALL not raise lookup_ready until the next cycle.

Reset
REQ-019 While rst_n=0 (asynchronously): state=RUN, FIFO empty, pointers 0, pred_valid=0, mispredict=0, resolve_err=0, mispredict_cnt=0, inflight_count=0.
REQ-020 While rst_n=0, lookup_ready=0, pred_request=0 and pred_result=0. Reset mid-operation SHALL discard all outstanding branches without any predictor update.

Verification
REQ-021 Reset, then a lookup in cycle 1 with a fresh predictor (state 0) -> pred_request=1 in cycle 1; pred_valid=1 and pred_taken=0 in cycle 2; inflight_count=1 in cycle 2 and cycle 3.
REQ-022 Four back-to-back lookups with no resolves -> lookup_ready=0 once inflight_count=4; a fifth lookup_valid is not accepted; one resolve restores lookup_ready the following cycle.
REQ-023 Resolve taken twice for two not-taken predictions -> mispredict pulses twice; mispredict_cnt=2; a subsequent lookup yields pred_taken=1 (predictor state 2).
REQ-024 Three outstanding branches, first resolves mispredicted -> mispredict=1 and FLUSH in the next cycle; inflight_count=0; lookup_ready=0 for exactly one cycle.
REQ-025 resolve_valid with the FIFO empty -> resolve_err=1 for one cycle; pred_result=0; mispredict_cnt unchanged.
REQ-026 256 consecutive mispredicts -> mispredict_cnt=255 (saturates). Asserting rst_n=0 mid-stream -> all state cleared immediately, with no clock edge required.
